// File: rtl/pc_unit.sv
// pc_unit: program counter with INIT/RUN/FAULT control, fetch handshake and circular return-address stack.
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int ALIGN_BITS = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable_n,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_kind,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] address,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(1) << ALIGN_BITS;
  localparam logic [XLEN-1:0] MASK = STEP - XLEN'(1);

  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

  state_t state, state_n;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [XLEN-1:0] address_n, seq, tgt;
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  logic [CW-1:0] count;
  logic mis_n, active, trap, push, pop;

  assign active = !enable_n;
  assign trap = redirect_valid && redirect_kind == 2'b11;
  assign seq = address + STEP;
  assign ptr_inc = ptr == PW'(RAS_DEPTH - 1) ? '0 : ptr + PW'(1);
  assign ptr_dec = ptr == '0 ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);
  assign tgt = (redirect_kind == 2'b10 && !ras_empty) ? ras[ptr_dec] : redirect_target;
  assign push = active && state == RUN && redirect_valid && redirect_kind == 2'b01;
  assign pop = active && state == RUN && redirect_valid && redirect_kind == 2'b10 && !ras_empty;
  assign ras_empty = count == '0;
  assign ras_full = count == CW'(RAS_DEPTH);
  assign fetch_valid = state == RUN;

  always_comb begin
    state_n = state;
    address_n = address;
    mis_n = misaligned;
    if (active) begin
      if (trap) begin
        address_n = trap_vector & ~MASK;
        mis_n = 1'b0;
        state_n = RUN;
      end else if (state == INIT) begin
        state_n = RUN;
      end else if (state == RUN) begin
        if (redirect_valid) begin
          address_n = tgt;
          mis_n = |(tgt & MASK);
          state_n = |(tgt & MASK) ? FAULT : RUN;
        end else if (fetch_ready) begin
          address_n = seq;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      address <= RESET_VECTOR;
      misaligned <= 1'b0;
      ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      address <= address_n;
      misaligned <= mis_n;
      ptr <= push ? ptr_inc : pop ? ptr_dec : ptr;
      count <= push ? (ras_full ? count : count + CW'(1)) : pop ? count - CW'(1) : count;
    end
  end

  // On overflow ptr has wrapped onto the oldest slot, so the push overwrites it.
  always_ff @(posedge clk) begin
    if (push) ras[ptr] <= seq;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with a queued scoreboard checked one cycle after each drive.
module tb_pc_unit;
  logic clk = 0, reset_n = 0, enable_n = 0, redirect_valid = 0, fetch_ready = 0;
  logic [1:0] redirect_kind = 0;
  logic [31:0] redirect_target = 0, trap_vector = 0;
  logic fetch_valid, misaligned, ras_empty, ras_full;
  logic [31:0] address;
  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] a;
    logic fv, mis, emp, full;
    string nm;
  } exp_t;
  exp_t q[$];

  pc_unit dut (
    .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind), .redirect_target(redirect_target), .trap_vector(trap_vector),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .address(address),
    .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input exp_t e);
    total++;
    if ({address, fetch_valid, misaligned, ras_empty, ras_full} !== {e.a, e.fv, e.mis, e.emp, e.full}) begin
      bad++;
      $display("FAIL %s: got addr=%h fv=%b mis=%b emp=%b full=%b, want addr=%h fv=%b mis=%b emp=%b full=%b",
               e.nm, address, fetch_valid, misaligned, ras_empty, ras_full, e.a, e.fv, e.mis, e.emp, e.full);
    end
  endtask

  // Called at a negedge: drive, queue the post-edge expectation, advance to the next negedge.
  task automatic cyc(input logic en_n, input logic rv, input logic [1:0] k, input logic [31:0] tg,
                     input logic [31:0] tv, input logic fr, input logic [31:0] ea, input logic efv,
                     input logic emis, input logic eemp, input logic efull, input string nm);
    exp_t e;
    enable_n = en_n; redirect_valid = rv; redirect_kind = k; redirect_target = tg;
    trap_vector = tv; fetch_ready = fr;
    e.a = ea; e.fv = efv; e.mis = emis; e.emp = eemp; e.full = efull; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) chk(q.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t r;
    #3;
    r.a = 0; r.fv = 0; r.mis = 0; r.emp = 1; r.full = 0; r.nm = "reset";
    chk(r);
    @(negedge clk);
    reset_n = 1;
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h0, 1, 0, 1, 0, "init_to_run");
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h4, 1, 0, 1, 0, "inc1");
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h8, 1, 0, 1, 0, "inc2");
    cyc(0, 1, 2'b00, 32'h10, 0, 0, 32'h10, 1, 0, 1, 0, "jump_no_ready");
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h14, 1, 0, 1, 0, "hs1");
    cyc(0, 0, 2'b00, 0, 0, 0, 32'h14, 1, 0, 1, 0, "hold1");
    cyc(0, 0, 2'b00, 0, 0, 0, 32'h14, 1, 0, 1, 0, "hold2");
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h18, 1, 0, 1, 0, "hs2");
    cyc(1, 1, 2'b00, 32'h500, 0, 1, 32'h18, 1, 0, 1, 0, "disabled");
    cyc(0, 1, 2'b00, 32'h20, 0, 1, 32'h20, 1, 0, 1, 0, "jump20");
    cyc(0, 1, 2'b01, 32'h100, 0, 1, 32'h100, 1, 0, 0, 0, "call100");
    cyc(0, 1, 2'b10, 32'h900, 0, 1, 32'h24, 1, 0, 1, 0, "ret24");
    cyc(0, 1, 2'b10, 32'h900, 0, 1, 32'h900, 1, 0, 1, 0, "ret_empty");
    cyc(0, 1, 2'b00, 32'h0, 0, 1, 32'h0, 1, 0, 1, 0, "jump0");
    cyc(0, 1, 2'b01, 32'h40, 0, 1, 32'h40, 1, 0, 0, 0, "call1");
    cyc(0, 1, 2'b01, 32'h80, 0, 1, 32'h80, 1, 0, 0, 0, "call2");
    cyc(0, 1, 2'b01, 32'hC0, 0, 1, 32'hC0, 1, 0, 0, 0, "call3");
    cyc(0, 1, 2'b01, 32'h100, 0, 1, 32'h100, 1, 0, 0, 1, "call4_full");
    cyc(0, 1, 2'b01, 32'h200, 0, 1, 32'h200, 1, 0, 0, 1, "call5_over");
    cyc(0, 1, 2'b10, 32'h300, 0, 1, 32'h104, 1, 0, 0, 0, "ret1");
    cyc(0, 1, 2'b10, 32'h300, 0, 1, 32'hC4, 1, 0, 0, 0, "ret2");
    cyc(0, 1, 2'b10, 32'h300, 0, 1, 32'h84, 1, 0, 0, 0, "ret3");
    cyc(0, 1, 2'b10, 32'h300, 0, 1, 32'h44, 1, 0, 1, 0, "ret4");
    cyc(0, 1, 2'b10, 32'h300, 0, 1, 32'h300, 1, 0, 1, 0, "ret5_fallback");
    cyc(0, 1, 2'b00, 32'hFFFFFFFC, 0, 1, 32'hFFFFFFFC, 1, 0, 1, 0, "jump_top");
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h0, 1, 0, 1, 0, "wrap");
    cyc(0, 1, 2'b00, 32'h102, 0, 1, 32'h102, 0, 1, 1, 0, "misalign");
    cyc(0, 0, 2'b00, 0, 0, 1, 32'h102, 0, 1, 1, 0, "fault_hold");
    cyc(0, 1, 2'b01, 32'h400, 0, 1, 32'h102, 0, 1, 1, 0, "fault_call_ign");
    cyc(0, 1, 2'b11, 0, 32'h203, 1, 32'h200, 1, 0, 1, 0, "trap_exit");
    cyc(0, 1, 2'b01, 32'h500, 0, 1, 32'h500, 1, 0, 0, 0, "call500");
    enable_n = 0; redirect_valid = 1; redirect_kind = 2'b01; redirect_target = 32'h600;
    #2 reset_n = 0;
    #1;
    r.a = 0; r.fv = 0; r.mis = 0; r.emp = 1; r.full = 0; r.nm = "async_reset";
    chk(r);
    redirect_valid = 0;
    @(negedge clk);
    reset_n = 1;
    cyc(0, 1, 2'b00, 32'h700, 0, 1, 32'h0, 1, 0, 1, 0, "init_jump_ign");
    cyc(0, 1, 2'b01, 32'h40, 0, 0, 32'h40, 1, 0, 0, 0, "call_after_reset");
    cyc(0, 0, 2'b00, 0, 0, 0, 32'h40, 1, 0, 0, 0, "idle");
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
